// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - execute-stage ALU, ALU control decode, status flags and PC adders
//
// Purpose: execute-stage datapath for the single-cycle MIPS-lite core. Decodes
// aluop/funct into a 4-bit ALU operation, computes the ALU result with zero
// detect, keeps N/V/Z flags from the most recent R-type instruction, and forms
// PC+4 and the branch target.
//
// Ports:
//   clk        in   system clock, flags update on rising edge
//   reset      in   asynchronous active-high, clears flags
//   aluop      in   [1:0] from main control
//   funct      in   [5:0] instruction function field
//   a, b       in   [WIDTH-1:0] ALU operands
//   pc         in   [WIDTH-1:0] current program counter
//   br_offset  in   [WIDTH-1:0] sign-extended branch offset in words
//   gout       out  [3:0] decoded ALU operation
//   result     out  [WIDTH-1:0] ALU result (combinational)
//   zero       out  result == 0 (combinational)
//   status_n   out  registered negative flag
//   status_v   out  registered signed-overflow flag
//   status_z   out  registered zero flag
//   pc_plus4   out  [WIDTH-1:0] pc + 4
//   br_target  out  [WIDTH-1:0] pc_plus4 + (br_offset << 2)

module alu_exec_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       aluop,
   input  logic [5:0]       funct,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] pc,
   input  logic [WIDTH-1:0] br_offset,
   output logic [3:0]       gout,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             status_n,
   output logic             status_v,
   output logic             status_z,
   output logic [WIDTH-1:0] pc_plus4,
   output logic [WIDTH-1:0] br_target
);

   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_OR  = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_XOR = 4'b0011;
   localparam logic [3:0] OP_SUB = 4'b0110;
   localparam logic [3:0] OP_SLT = 4'b0111;
   localparam logic [3:0] OP_NOR = 4'b1100;

   logic             overflow;
   logic [WIDTH-1:0] sum;
   logic [WIDTH-1:0] diff;
   logic             n_d, v_d, z_d;
   logic             n_q, v_q, z_q;

   // ALU control decode
   always_comb begin
      gout = OP_ADD;
      case (aluop)
         2'b00: gout = OP_ADD;
         2'b01: gout = OP_SUB;
         2'b11: gout = OP_NOR;
         2'b10: begin
            case (funct)
               6'b100000: gout = OP_ADD;
               6'b100010: gout = OP_SUB;
               6'b100100: gout = OP_AND;
               6'b100101: gout = OP_OR;
               6'b100110: gout = OP_XOR;
               6'b100111: gout = OP_NOR;
               6'b101010: gout = OP_SLT;
               default:   gout = OP_ADD;
            endcase
         end
         default: gout = OP_ADD;
      endcase
   end

   assign sum  = a + b;
   assign diff = a - b;

   always_comb begin
      result   = '0;
      overflow = 1'b0;
      case (gout)
         OP_AND: result = a & b;
         OP_OR:  result = a | b;
         OP_XOR: result = a ^ b;
         OP_NOR: result = ~(a | b);
         OP_ADD: begin
            result   = sum;
            overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB: begin
            result   = diff;
            overflow = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SLT: result = ($signed(a) < $signed(b)) ? WIDTH'(1) : '0;
         default: result = '0;
      endcase
   end

   assign zero = (result == '0);

   // Flags capture only on R-type so later flag branches see the last R-type outcome
   always_comb begin
      n_d = n_q;
      v_d = v_q;
      z_d = z_q;
      if (aluop == 2'b10) begin
         n_d = result[WIDTH-1];
         v_d = overflow;
         z_d = zero;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         n_q <= 1'b0;
         v_q <= 1'b0;
         z_q <= 1'b0;
      end else begin
         n_q <= n_d;
         v_q <= v_d;
         z_q <= z_d;
      end
   end

   assign status_n = n_q;
   assign status_v = v_q;
   assign status_z = z_q;

   assign pc_plus4  = pc + WIDTH'(4);
   assign br_target = pc_plus4 + {br_offset[WIDTH-3:0], 2'b00};

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - directed self-checking bench for alu_exec_unit

module tb_alu_exec_unit;

   logic        clk;
   logic        reset;
   logic [1:0]  aluop;
   logic [5:0]  funct;
   logic [31:0] a, b, pc, br_offset;
   logic [3:0]  gout;
   logic [31:0] result;
   logic        zero, status_n, status_v, status_z;
   logic [31:0] pc_plus4, br_target;

   int checks = 0;
   int errors = 0;

   alu_exec_unit #(.WIDTH(32)) dut (
      .clk       (clk),
      .reset     (reset),
      .aluop     (aluop),
      .funct     (funct),
      .a         (a),
      .b         (b),
      .pc        (pc),
      .br_offset (br_offset),
      .gout      (gout),
      .result    (result),
      .zero      (zero),
      .status_n  (status_n),
      .status_v  (status_v),
      .status_z  (status_z),
      .pc_plus4  (pc_plus4),
      .br_target (br_target)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // drive new inputs mid low-phase, settle
   task automatic apply(input logic [1:0] op, input logic [5:0] fn,
                        input logic [31:0] va, input logic [31:0] vb);
      @(negedge clk);
      aluop = op;
      funct = fn;
      a     = va;
      b     = vb;
      #1;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check_flags(input string tag, input logic n, input logic v, input logic z);
      check_val({tag, "_n"}, {31'd0, status_n}, {31'd0, n});
      check_val({tag, "_v"}, {31'd0, status_v}, {31'd0, v});
      check_val({tag, "_z"}, {31'd0, status_z}, {31'd0, z});
   endtask

   initial begin
      reset     = 1'b1;
      aluop     = 2'b00;
      funct     = 6'd0;
      a         = 32'd0;
      b         = 32'd0;
      pc        = 32'd0;
      br_offset = 32'd0;
      #12;
      check_flags("reset", 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      reset = 1'b0;

      // signed overflow on ADD sets V and N
      apply(2'b10, 6'b100000, 32'h7FFFFFFF, 32'h1);
      check_val("add_ovf_result", result, 32'h80000000);
      check_val("add_gout", {28'd0, gout}, 32'h2);
      tick();
      check_flags("add_ovf", 1'b1, 1'b1, 1'b0);

      // asynchronous reset mid-cycle clears flags without a clock edge
      @(negedge clk);
      #2;
      reset = 1'b1;
      #1;
      check_flags("async_rst", 1'b0, 1'b0, 1'b0);
      reset = 1'b0;

      apply(2'b10, 6'b100010, 32'd5, 32'd5);
      check_val("sub_eq_zero", {31'd0, zero}, 32'd1);
      check_val("sub_eq_result", result, 32'd0);
      tick();
      check_flags("sub_eq", 1'b0, 1'b0, 1'b1);

      // SUB overflow: most negative minus one
      apply(2'b10, 6'b100010, 32'h80000000, 32'h1);
      check_val("sub_ovf_result", result, 32'h7FFFFFFF);
      tick();
      check_flags("sub_ovf", 1'b0, 1'b1, 1'b0);

      // SLT signed comparisons
      apply(2'b10, 6'b101010, 32'hFFFFFFFF, 32'h1);
      check_val("slt_neg_lt_pos", result, 32'd1);
      check_val("slt_gout", {28'd0, gout}, 32'h7);
      apply(2'b10, 6'b101010, 32'h1, 32'hFFFFFFFF);
      check_val("slt_pos_lt_neg", result, 32'd0);
      check_val("slt_zero", {31'd0, zero}, 32'd1);

      // logic ops
      apply(2'b10, 6'b100100, 32'hF0F0F0F0, 32'h0FF00FF0);
      check_val("and", result, 32'h00F000F0);
      check_val("and_gout", {28'd0, gout}, 32'h0);
      apply(2'b10, 6'b100101, 32'hF0F0F0F0, 32'h0FF00FF0);
      check_val("or", result, 32'hFFF0FFF0);
      check_val("or_gout", {28'd0, gout}, 32'h1);
      apply(2'b10, 6'b100110, 32'hF0F0F0F0, 32'h0FF00FF0);
      check_val("xor", result, 32'hFF00FF00);
      check_val("xor_gout", {28'd0, gout}, 32'h3);
      apply(2'b10, 6'b100111, 32'hF0F0F0F0, 32'h0FF00FF0);
      check_val("nor", result, 32'h000F000F);
      check_val("nor_gout", {28'd0, gout}, 32'hC);
      apply(2'b11, 6'b000000, 32'hF0F0F0F0, 32'h0FF00FF0);
      check_val("nor_aluop11", result, 32'h000F000F);
      check_val("nor_aluop11_gout", {28'd0, gout}, 32'hC);

      // aluop 01 is SUB regardless of funct
      apply(2'b01, 6'b100100, 32'd10, 32'd3);
      check_val("aluop01_result", result, 32'd7);
      check_val("aluop01_gout", {28'd0, gout}, 32'h6);

      // flags from R-type SUB, then hold under non-R-type
      apply(2'b10, 6'b100010, 32'd3, 32'd7);
      check_val("sub_neg_result", result, 32'hFFFFFFFC);
      tick();
      check_flags("sub_neg", 1'b1, 1'b0, 1'b0);
      apply(2'b00, 6'b000000, 32'd0, 32'd0);
      check_val("hold_zero", {31'd0, zero}, 32'd1);
      tick();
      check_flags("hold1", 1'b1, 1'b0, 1'b0);
      tick();
      check_flags("hold2", 1'b1, 1'b0, 1'b0);

      // unknown funct falls back to ADD
      apply(2'b10, 6'b111111, 32'd2, 32'd3);
      check_val("unk_funct_gout", {28'd0, gout}, 32'h2);
      check_val("unk_funct_result", result, 32'd5);

      // adders
      pc        = 32'h10;
      br_offset = 32'hFFFFFFFE;
      #1;
      check_val("pc_plus4", pc_plus4, 32'h14);
      check_val("br_target_back", br_target, 32'h0C);
      pc        = 32'hFFFFFFFC;
      br_offset = 32'h3;
      #1;
      check_val("pc_plus4_wrap", pc_plus4, 32'h0);
      check_val("br_target_fwd", br_target, 32'hC);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
